// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register, one-outstanding imem requests, IF/ID register with skid buffer
// Optional FETCH_ALIGN_CHECK_EN: word-aligns redirect targets and pulses misalign_o on unaligned ones.
module fetch_pc_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [PC_W-1:0] if_pc_o,
    output logic [31:0]     if_instr_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            misalign_o
`endif
);

    localparam logic [2:0]      ST_RST  = 3'd0;
    localparam logic [2:0]      ST_REQ  = 3'd1;
    localparam logic [2:0]      ST_WAIT = 3'd2;
    localparam logic [2:0]      ST_HOLD = 3'd3;
    localparam logic [2:0]      ST_KILL = 3'd4;
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            if_valid_q, if_valid_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] redirect_tgt;
    logic            unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc_i[31:PC_W];

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redirect_tgt = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign misalign_d   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign misalign_o   = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign redirect_tgt = redirect_pc_i[PC_W-1:0];
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        // Decode consumed the held instruction; a new one may overwrite this below.
        if (!stall_i) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_RST: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt_i) begin
                    pc_d     = pc_q + PC_STEP;
                    req_pc_d = pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (!if_valid_q || !stall_i) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem_rdata_i;
                        state_d    = ST_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            ST_KILL: begin
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A granted-but-unanswered request must drain in KILL so only one is ever outstanding.
        if (redirect_i) begin
            pc_d         = redirect_tgt;
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            if ((((state_q == ST_WAIT) || (state_q == ST_KILL)) && !imem_rvalid_i) ||
                ((state_q == ST_REQ) && imem_gnt_i)) begin
                state_d = ST_KILL;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem_req_o  = (state_q == ST_REQ);
    assign imem_addr_o = pc_q;
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;

endmodule
